// File: rtl/urisc_pkg.sv
// Shared uRISC definitions: opcode encodings, ALU operation enum, slot state
// and the opcode/function to ALU-operation mapping used by the execute stage.
package urisc_pkg;

    localparam logic [4:0] OP_HALT  = 5'b00000;
    localparam logic [4:0] OP_NOP   = 5'b00001;
    localparam logic [4:0] OP_SIYS  = 5'b00010;
    localparam logic [4:0] OP_RTI   = 5'b00011;
    localparam logic [4:0] OP_J     = 5'b00100;
    localparam logic [4:0] OP_JR    = 5'b00101;
    localparam logic [4:0] OP_JAL   = 5'b00110;
    localparam logic [4:0] OP_JALR  = 5'b00111;
    localparam logic [4:0] OP_ADDI  = 5'b01000;
    localparam logic [4:0] OP_SUBI  = 5'b01001;
    localparam logic [4:0] OP_XORI  = 5'b01010;
    localparam logic [4:0] OP_ANDNI = 5'b01011;
    localparam logic [4:0] OP_BEQZ  = 5'b01100;
    localparam logic [4:0] OP_BNEZ  = 5'b01101;
    localparam logic [4:0] OP_BLTZ  = 5'b01110;
    localparam logic [4:0] OP_BGEZ  = 5'b01111;
    localparam logic [4:0] OP_ST    = 5'b10000;
    localparam logic [4:0] OP_LD    = 5'b10001;
    localparam logic [4:0] OP_SLBI  = 5'b10010;
    localparam logic [4:0] OP_STU   = 5'b10011;
    localparam logic [4:0] OP_ROLI  = 5'b10100;
    localparam logic [4:0] OP_SLLI  = 5'b10101;
    localparam logic [4:0] OP_RORI  = 5'b10110;
    localparam logic [4:0] OP_SRLI  = 5'b10111;
    localparam logic [4:0] OP_LBI   = 5'b11000;
    localparam logic [4:0] OP_BTR   = 5'b11001;
    localparam logic [4:0] OP_SHIFT = 5'b11010;
    localparam logic [4:0] OP_ARITH = 5'b11011;
    localparam logic [4:0] OP_SEQ   = 5'b11100;
    localparam logic [4:0] OP_SLT   = 5'b11101;
    localparam logic [4:0] OP_SLE   = 5'b11110;
    localparam logic [4:0] OP_SCO   = 5'b11111;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_XOR, ALU_ANDN,
        ALU_ROL, ALU_SLL, ALU_ROR, ALU_SRL,
        ALU_SEQ, ALU_SLT, ALU_SLE, ALU_SCO,
        ALU_BTR, ALU_PASSB, ALU_SLBI
    } alu_op_e;

    typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_state_e;

    // Address generation and all control transfers fall through to ADD.
    function automatic alu_op_e decode_alu_op(input logic [4:0] opcode, input logic [1:0] func);
        alu_op_e op;
        op = ALU_ADD;
        case (opcode)
            OP_SUBI:  op = ALU_SUB;
            OP_XORI:  op = ALU_XOR;
            OP_ANDNI: op = ALU_ANDN;
            OP_ROLI:  op = ALU_ROL;
            OP_SLLI:  op = ALU_SLL;
            OP_RORI:  op = ALU_ROR;
            OP_SRLI:  op = ALU_SRL;
            OP_ARITH: op = (func == 2'b00) ? ALU_ADD : (func == 2'b01) ? ALU_SUB :
                           (func == 2'b10) ? ALU_XOR : ALU_ANDN;
            OP_SHIFT: op = (func == 2'b00) ? ALU_ROL : (func == 2'b01) ? ALU_SLL :
                           (func == 2'b10) ? ALU_ROR : ALU_SRL;
            OP_SEQ:   op = ALU_SEQ;
            OP_SLT:   op = ALU_SLT;
            OP_SLE:   op = ALU_SLE;
            OP_SCO:   op = ALU_SCO;
            OP_BTR:   op = ALU_BTR;
            OP_LBI:   op = ALU_PASSB;
            OP_SLBI:  op = ALU_SLBI;
            default:  op = ALU_ADD;
        endcase
        return op;
    endfunction

    function automatic logic uses_rt(input logic [4:0] opcode);
        return (opcode == OP_SHIFT) || (opcode == OP_ARITH) || (opcode[4:2] == 3'b111);
    endfunction

endpackage

// File: rtl/execute_alu.sv
// Combinational 16-bit ALU; wraps on overflow. The 17-bit add carry is
// exported so the stage can form the SCO result from it.
module alu
    import urisc_pkg::*;
#(
    parameter int XLEN = 16
) (
    input  alu_op_e         op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result,
    output logic            carry
);

    logic [XLEN:0]     sum;
    logic [3:0]        sh;
    logic [2*XLEN-1:0] rol_w;
    logic [2*XLEN-1:0] ror_w;

    assign sum   = {1'b0, a} + {1'b0, b};
    assign sh    = b[3:0];
    assign rol_w = {a, a} << sh;
    assign ror_w = {a, a} >> sh;
    assign carry = sum[XLEN];

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        result = '0;
        case (op)
            ALU_ADD, ALU_SCO: result = sum[XLEN-1:0];
            ALU_SUB:   result = b - a;
            ALU_XOR:   result = a ^ b;
            ALU_ANDN:  result = a & ~b;
            ALU_ROL:   result = rol_w[2*XLEN-1:XLEN];
            ALU_SLL:   result = a << sh;
            ALU_ROR:   result = ror_w[XLEN-1:0];
            ALU_SRL:   result = a >> sh;
            ALU_SEQ:   result = {{(XLEN-1){1'b0}}, a == b};
            ALU_SLT:   result = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_SLE:   result = {{(XLEN-1){1'b0}}, $signed(a) <= $signed(b)};
            ALU_BTR:   for (int i = 0; i < XLEN; i++) result[i] = a[XLEN-1-i];
            ALU_PASSB: result = b;
            ALU_SLBI:  result = (a << 8) | {{(XLEN-8){1'b0}}, b[7:0]};
            default:   result = '0;
        endcase
    end

endmodule

// File: rtl/execute.sv
// uRISC execute stage: ALU/address/branch evaluation into a registered EX/MEM
// slot with valid/ready handshake and a one-cycle redirect pulse to fetch.
module execute
    import urisc_pkg::*;
#(
    parameter int XLEN = 16,
    parameter int REGW = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            execute_valid_idix_p1,
    input  logic [4:0]      opcode_idix_p1,
    input  logic [1:0]      func_idix_p1,
    input  logic [REGW-1:0] rd_idix_p1,
    input  logic [XLEN-1:0] rs_val_idix_p1,
    input  logic [XLEN-1:0] rt_val_idix_p1,
    input  logic [XLEN-1:0] imm_idix_p1,
    input  logic [XLEN-1:0] pc_idix_p1,
    input  logic [25:0]     uop_cnt_idix_p1,
    input  logic            flush_ix_p1,
    input  logic            mem_ready_p1,
    output logic            ready_ixid_p1,
    output logic            valid_ixmem_p1,
    output logic [XLEN-1:0] result_ixmem_p1,
    output logic [XLEN-1:0] store_data_ixmem_p1,
    output logic [REGW-1:0] rd_ixmem_p1,
    output logic            wb_en_ixmem_p1,
    output logic            ld_ixmem_p1,
    output logic            st_ixmem_p1,
    output logic [25:0]     uop_cnt_ixmem_p1,
    output logic            redirect_ixif_p1,
    output logic [XLEN-1:0] redirect_pc_ixif_p1
);

    slot_state_e     state_q, state_d;
    alu_op_e         alu_op;
    logic            accept, taken, alu_carry, wb_en_d, ld_d, st_d;
    logic [XLEN-1:0] op2, alu_result, pc_plus2, result_d, target_d;

    assign valid_ixmem_p1 = (state_q == SLOT_FULL);
    assign ready_ixid_p1  = !valid_ixmem_p1 || mem_ready_p1;
    assign accept         = execute_valid_idix_p1 && ready_ixid_p1 && !flush_ix_p1;

    assign alu_op   = decode_alu_op(opcode_idix_p1, func_idix_p1);
    assign op2      = uses_rt(opcode_idix_p1) ? rt_val_idix_p1 : imm_idix_p1;
    assign pc_plus2 = pc_idix_p1 + XLEN'(2);

    alu #(.XLEN(XLEN)) u_alu (
        .op     (alu_op),
        .a      (rs_val_idix_p1),
        .b      (op2),
        .result (alu_result),
        .carry  (alu_carry)
    );

    always_comb begin
        result_d = alu_result;
        target_d = pc_plus2 + imm_idix_p1;
        taken    = 1'b0;
        wb_en_d  = 1'b0;
        ld_d     = 1'b0;
        st_d     = 1'b0;
        case (opcode_idix_p1)
            OP_BEQZ: taken = (rs_val_idix_p1 == '0);
            OP_BNEZ: taken = (rs_val_idix_p1 != '0);
            OP_BLTZ: taken = rs_val_idix_p1[XLEN-1];
            OP_BGEZ: taken = !rs_val_idix_p1[XLEN-1];
            OP_J:    taken = 1'b1;
            OP_JR:   begin taken = 1'b1; target_d = alu_result; end
            OP_JAL:  begin taken = 1'b1; wb_en_d = 1'b1; result_d = pc_plus2; end
            OP_JALR: begin
                taken    = 1'b1;
                wb_en_d  = 1'b1;
                target_d = alu_result;
                result_d = pc_plus2;
            end
            OP_ST:   st_d = 1'b1;
            OP_LD:   begin ld_d = 1'b1; wb_en_d = 1'b1; end
            OP_STU:  begin st_d = 1'b1; wb_en_d = 1'b1; end
            OP_SCO:  begin wb_en_d = 1'b1; result_d = {{(XLEN-1){1'b0}}, alu_carry}; end
            OP_ADDI, OP_SUBI, OP_XORI, OP_ANDNI, OP_SLBI, OP_ROLI, OP_SLLI, OP_RORI,
            OP_SRLI, OP_LBI, OP_BTR, OP_SHIFT, OP_ARITH, OP_SEQ, OP_SLT, OP_SLE:
                     wb_en_d = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        if (flush_ix_p1)       state_d = SLOT_EMPTY;
        else if (accept)       state_d = SLOT_FULL;
        else if (mem_ready_p1) state_d = SLOT_EMPTY;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= SLOT_EMPTY;
        else     state_q <= state_d;
    end

    // Redirect is only raised on the accepting edge, so a stalled slot never repeats it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_ixmem_p1     <= '0;
            store_data_ixmem_p1 <= '0;
            rd_ixmem_p1         <= '0;
            wb_en_ixmem_p1      <= 1'b0;
            ld_ixmem_p1         <= 1'b0;
            st_ixmem_p1         <= 1'b0;
            uop_cnt_ixmem_p1    <= '0;
            redirect_ixif_p1    <= 1'b0;
            redirect_pc_ixif_p1 <= '0;
        end else begin
            redirect_ixif_p1 <= accept && taken;
            if (accept) begin
                result_ixmem_p1     <= result_d;
                store_data_ixmem_p1 <= rt_val_idix_p1;
                rd_ixmem_p1         <= rd_idix_p1;
                wb_en_ixmem_p1      <= wb_en_d;
                ld_ixmem_p1         <= ld_d;
                st_ixmem_p1         <= st_d;
                uop_cnt_ixmem_p1    <= uop_cnt_idix_p1;
                redirect_pc_ixif_p1 <= target_d;
            end
        end
    end

endmodule

// File: doc/execute.md
# execute

Execute stage of the uRISC pipeline, directly downstream of `decode`. It accepts one decoded instruction per cycle from the ID/EX boundary, computes the ALU result, memory address or branch/jump outcome, and holds the result in a registered EX/MEM slot for the memory stage under a valid/ready handshake. It also forwards the instruction's uop count and raises a one-cycle redirect to fetch on a taken control transfer.

## Interface
- `XLEN`, 16: datapath width.
- `REGW`, 3: register index width.
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `execute_valid_idix_p1`  in  1  instruction presented by decode.
- `opcode_idix_p1`  in  5  opcode.
- `func_idix_p1`  in  2  R-format function field.
- `rd_idix_p1`  in  3  destination register index.
- `rs_val_idix_p1`, `rt_val_idix_p1`  in  16  operand values from regfile.
- `imm_idix_p1`  in  16  immediate, already sign/zero-extended by decode.
- `pc_idix_p1`  in  16  PC of the instruction.
- `uop_cnt_idix_p1`  in  26  uop sequence number.
- `flush_ix_p1`  in  1  squash the incoming instruction and the EX/MEM slot.
- `mem_ready_p1`  in  1  memory stage accepts the EX/MEM slot.
- `ready_ixid_p1`  out  1  execute can accept this cycle.
- `valid_ixmem_p1`  out  1  EX/MEM slot occupied.
- `result_ixmem_p1`  out  16  ALU result or effective address.
- `store_data_ixmem_p1`  out  16  rt value for stores.
- `rd_ixmem_p1`  out  3  writeback index.
- `wb_en_ixmem_p1`, `ld_ixmem_p1`, `st_ixmem_p1`  out  1  writeback / load / store flags.
- `uop_cnt_ixmem_p1`  out  26  forwarded uop count.
- `redirect_ixif_p1`  out  1  one-cycle taken-branch/jump pulse.
- `redirect_pc_ixif_p1`  out  16  redirect target.

## Operation
- Accept = `execute_valid_idix_p1 & ready_ixid_p1 & !flush_ix_p1`; `ready_ixid_p1 = !valid_ixmem_p1 | mem_ready_p1` (combinational).
- Slot FSM has two states: EMPTY and FULL. EMPTY→FULL on accept. FULL→EMPTY on `mem_ready_p1` with no accept. FULL→FULL (slot replaced) on `mem_ready_p1` and accept. Any state → EMPTY on flush.
- All slot fields load only on accept. Fields hold while FULL and not drained.
- Arithmetic is 16-bit and wraps with no overflow flag. ADD/SUB compute rs±rt (or imm). SUB computes operand−rs as per ISA. XOR. ANDN computes rs & ~op2.
- Shifts/rotates (ROL, SLL, ROR, SRL) use `op2[3:0]`.
- SEQ/SLT/SLE are signed compares and write 1 or 0. SCO writes the carry-out of the 17-bit rs+rt.
- BTR reverses the bits of rs. LBI passes imm. SLBI computes (rs<<8) | imm[7:0].
- LD/ST/STU address = rs+imm. STU also writes the address to rd.
- Branch condition tests rs: BEQZ ==0, BNEZ !=0, BLTZ <0, BGEZ >=0. Taken target = pc+2+imm.
- J target = pc+2+imm. JR target = rs+imm. JAL/JALR additionally write pc+2 to rd (decode supplies rd=7).
- HALT, NOP, SIYS and RTI pass through with `wb_en`=0. An illegal opcode is treated as NOP.

## Timing
- Latency is 1 cycle: inputs accepted at edge N appear on `*_ixmem_p1` after edge N.
- `redirect_ixif_p1` is registered and asserts for exactly one cycle, coincident with the first cycle that slot is valid. It is not reasserted while the slot stalls.
- Flush and accept in the same cycle: flush wins, nothing is captured, and no redirect is issued.
- Flush while FULL clears `valid_ixmem_p1` and `redirect_ixif_p1` on the next edge.
- Reset (asynchronous, any time including mid-stall) drives every output register to 0: `valid`, `redirect`, result, address, flags, `uop_cnt`.
- `ready_ixid_p1` is 1 out of reset.

## Structure
- `urisc_pkg` holds:
  - 5-bit opcode localparams (ADDI 01000, ADD-group 11011, BEQZ 01100, BNEZ 01101, J 00100, JAL 00110, LD 10001, ST 10000, SCO 11111, etc.).
  - the `alu_op_e` enum.
  - a `decode_alu_op(opcode, func)` function.
- One sub-module, `alu`, which is purely combinational (op, a, b → result, carry). The control-transfer evaluation and the slot FSM stay in `execute`.

## Test plan
- ADD with rs=0x7FFF, rt=0x0001 → after one edge, result=0x8000, wb_en=1, valid=1. SCO with rs=0xFFFF, rt=1 → result=0x0001.
- BEQZ with rs=0, pc=0x0010, imm=0x0004 → redirect=1 for one cycle with target 0x0016. With rs=5 → no redirect.
- JAL at pc=0x0100, imm=0xFFFE → target 0x0100, result=0x0102, rd=7, wb_en=1.
- Slot FULL with `mem_ready`=0 for 3 cycles → `ready_ixid`=0 and the slot holds. When `mem_ready` rises while a new instruction is valid, the slot is replaced in that cycle and no bubble appears.
- `flush` asserted together with a valid taken BNEZ → valid=0, redirect=0 next cycle.
- Assert `rst` mid-stall → all outputs 0 immediately (asynchronous). After release, `ready_ixid`=1 and `uop_cnt` forwards correctly (0x3FFFFFF passes unchanged).
